// File: rtl/isb_prefetch_buffer_if.sv
// Bundle of the prefetch, memory and demand channels of the ISB stream buffer.
// The buffer is the slave; the prefetcher, memory and demand side together form the master.
interface isb_prefetch_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pf_v;
  logic [AW-1:0] pf_addr;
  logic          pf_drop;

  logic          mem_req_v;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ack;
  logic          mem_resp_v;
  logic [DW-1:0] mem_resp_data;

  logic          dmd_v;
  logic [AW-1:0] dmd_addr;
  logic          dmd_hit;
  logic [DW-1:0] dmd_data;

  logic [CW-1:0] count;

  modport slave (
    input  pf_v, pf_addr, mem_req_ack, mem_resp_v, mem_resp_data, dmd_v, dmd_addr,
    output pf_drop, mem_req_v, mem_req_addr, dmd_hit, dmd_data, count
  );

  modport master (
    output pf_v, pf_addr, mem_req_ack, mem_resp_v, mem_resp_data, dmd_v, dmd_addr,
    input  pf_drop, mem_req_v, mem_req_addr, dmd_hit, dmd_data, count
  );
endinterface

// File: rtl/isb_prefetch_buffer.sv
// Stream buffer behind the ISB prefetcher: dedups candidates, issues them to memory in
// lowest-index order, buffers in-order responses and serves demand hits out of the buffer.
module isb_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  isb_prefetch_buffer_if.slave  pb_if
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    ST_INVALID,
    ST_QUEUED,
    ST_PENDING,
    ST_READY
  } entry_st_e;

  entry_st_e     state_q [DEPTH];
  entry_st_e     state_d [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];

  // Issue-order FIFO of entry indices; pointers carry one wrap bit.
  logic [IW-1:0] fifo_q  [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;

  logic          pf_drop_q, pf_drop_d;
  logic          dmd_hit_q, dmd_hit_d;
  logic [DW-1:0] dmd_data_q, dmd_data_d;

  logic          free_v;
  logic [IW-1:0] free_idx;
  logic          queued_v;
  logic [IW-1:0] queued_idx;
  logic          pf_dup;
  logic          dmd_match;
  logic [IW-1:0] dmd_idx;
  logic [CW-1:0] valid_cnt;

  logic          issue;
  logic          fifo_empty;
  logic          pop;
  logic [IW-1:0] head_idx;
  logic          alloc;
  logic          dmd_ready_hit;
  logic          dmd_cancel;

  // Start-of-cycle lookups shared by alloc, issue and demand.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    free_v     = 1'b0;
    free_idx   = '0;
    queued_v   = 1'b0;
    queued_idx = '0;
    pf_dup     = 1'b0;
    dmd_match  = 1'b0;
    dmd_idx    = '0;
    valid_cnt  = '0;
    // Scan downward so the last hit found is the lowest index.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_INVALID) begin
        free_v   = 1'b1;
        free_idx = IW'(i);
      end
      if (state_q[i] == ST_QUEUED) begin
        queued_v   = 1'b1;
        queued_idx = IW'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] != ST_INVALID) begin
        valid_cnt = valid_cnt + CW'(1);
        if (addr_q[i] == pb_if.pf_addr) pf_dup = 1'b1;
        if (addr_q[i] == pb_if.dmd_addr) begin
          dmd_match = 1'b1;
          dmd_idx   = IW'(i);
        end
      end
    end
  end

  assign issue      = queued_v && pb_if.mem_req_ack;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = pb_if.mem_resp_v && !fifo_empty;
  assign head_idx   = fifo_q[rd_ptr_q[IW-1:0]];
  assign alloc      = pb_if.pf_v && !pf_dup && free_v;

  assign dmd_ready_hit = pb_if.dmd_v && dmd_match && (state_q[dmd_idx] == ST_READY);
  // An ack on the same QUEUED entry takes priority over the cancel.
  assign dmd_cancel    = pb_if.dmd_v && dmd_match && (state_q[dmd_idx] == ST_QUEUED) &&
                         !(issue && (queued_idx == dmd_idx));

  // Entry FSMs: the indices touched in one cycle are distinct, except the ack/cancel
  // collision, which the cancel term already excludes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) state_d[i] = state_q[i];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pf_drop_d  = pb_if.pf_v && !alloc;
    dmd_hit_d  = dmd_ready_hit;
    dmd_data_d = dmd_ready_hit ? data_q[dmd_idx] : '0;

    if (alloc)         state_d[free_idx] = ST_QUEUED;
    if (dmd_ready_hit) state_d[dmd_idx]  = ST_INVALID;
    if (dmd_cancel)    state_d[dmd_idx]  = ST_INVALID;
    if (issue) begin
      state_d[queued_idx] = ST_PENDING;
      wr_ptr_d            = wr_ptr_q + CW'(1);
    end
    if (pop) begin
      state_d[head_idx] = ST_READY;
      rd_ptr_d          = rd_ptr_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples start-of-cycle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_INVALID;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pf_drop_q  <= 1'b0;
      dmd_hit_q  <= 1'b0;
      dmd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pf_drop_q  <= pf_drop_d;
      dmd_hit_q  <= dmd_hit_d;
      dmd_data_q <= dmd_data_d;
    end
  end

  // NOTE: payload arrays are not reset; they are only read while the owning entry or FIFO slot is live.
  always_ff @(posedge clk) begin
    if (alloc) addr_q[free_idx] <= pb_if.pf_addr;
    if (pop)   data_q[head_idx] <= pb_if.mem_resp_data;
    if (issue) fifo_q[wr_ptr_q[IW-1:0]] <= queued_idx;
  end

  assign pb_if.mem_req_v    = queued_v;
  assign pb_if.mem_req_addr = queued_v ? addr_q[queued_idx] : '0;
  assign pb_if.pf_drop      = pf_drop_q;
  assign pb_if.dmd_hit      = dmd_hit_q;
  assign pb_if.dmd_data     = dmd_data_q;
  assign pb_if.count        = valid_cnt;

endmodule

// File: tb/tb_isb_prefetch_buffer.sv
// Bench for isb_prefetch_buffer: directed scenarios, a slot/queue reference model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_isb_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  isb_prefetch_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus_if ();

  isb_prefetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pb_if (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot table plus an issue-order queue.
  typedef enum int {M_INV, M_Q, M_P, M_R} mst_e;
  mst_e          m_st   [DEPTH];
  logic [AW-1:0] m_addr [DEPTH];
  logic [DW-1:0] m_data [DEPTH];
  int            m_fifo [$];
  logic          m_drop;
  logic          m_hit;
  logic [DW-1:0] m_hdata;

  int qi, fi, mi, h;
  bit dup, iss, cancel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_st[i] = M_INV;
        m_addr[i] = '0;
        m_data[i] = '0;
      end
      m_fifo.delete();
      m_drop  = 1'b0;
      m_hit   = 1'b0;
      m_hdata = '0;
    end else begin
      qi = -1; fi = -1; mi = -1; dup = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (m_st[i] == M_Q)   qi = i;
        if (m_st[i] == M_INV) fi = i;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_st[i] != M_INV && m_addr[i] == bus_if.pf_addr)  dup = 1'b1;
        if (m_st[i] != M_INV && m_addr[i] == bus_if.dmd_addr) mi = i;
      end
      iss     = (qi >= 0) && bus_if.mem_req_ack;
      m_drop  = bus_if.pf_v && (dup || fi < 0);
      m_hit   = bus_if.dmd_v && (mi >= 0) && (m_st[mi] == M_R);
      m_hdata = m_hit ? m_data[mi] : '0;
      cancel  = bus_if.dmd_v && (mi >= 0) && (m_st[mi] == M_Q) && !(iss && qi == mi);

      if (bus_if.mem_resp_v && m_fifo.size() > 0) begin
        h = m_fifo.pop_front();
        m_st[h]   = M_R;
        m_data[h] = bus_if.mem_resp_data;
      end
      if (iss) begin
        m_st[qi] = M_P;
        m_fifo.push_back(qi);
      end
      if (m_hit || cancel) m_st[mi] = M_INV;
      if (bus_if.pf_v && !m_drop) begin
        m_st[fi]   = M_Q;
        m_addr[fi] = bus_if.pf_addr;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin : cmp
    int       cnt;
    int       lq;
    cnt = 0;
    lq  = -1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_st[i] != M_INV) cnt++;
      if (m_st[i] == M_Q) lq = i;
    end
    check("model_count",    32'(bus_if.count),     32'(cnt));
    check("model_req_v",    32'(bus_if.mem_req_v), 32'(lq >= 0));
    check("model_req_addr", 32'(bus_if.mem_req_addr), (lq >= 0) ? 32'(m_addr[lq]) : 32'd0);
    check("model_pf_drop",  32'(bus_if.pf_drop),   32'(m_drop));
    check("model_dmd_hit",  32'(bus_if.dmd_hit),   32'(m_hit));
    check("model_dmd_data", 32'(bus_if.dmd_data),  32'(m_hdata));
  end

  // Drive one cycle of inputs at negedge+1, return at the following negedge+1.
  task automatic step(input logic pv, input logic [AW-1:0] pa, input logic ack,
                      input logic rv, input logic [DW-1:0] rd,
                      input logic dv, input logic [AW-1:0] da);
    bus_if.pf_v          = pv;
    bus_if.pf_addr       = pa;
    bus_if.mem_req_ack   = ack;
    bus_if.mem_resp_v    = rv;
    bus_if.mem_resp_data = rd;
    bus_if.dmd_v         = dv;
    bus_if.dmd_addr      = da;
    @(negedge clk);
    #1;
  endtask

  task automatic pf(input logic [AW-1:0] a);   step(1, a, 0, 0, '0, 0, '0); endtask
  task automatic ack();                        step(0, '0, 1, 0, '0, 0, '0); endtask
  task automatic resp(input logic [DW-1:0] d); step(0, '0, 0, 1, d, 0, '0); endtask
  task automatic dmd(input logic [AW-1:0] a);  step(0, '0, 0, 0, '0, 1, a); endtask
  task automatic idle();                       step(0, '0, 0, 0, '0, 0, '0); endtask

  initial begin
    bus_if.pf_v = 0; bus_if.pf_addr = '0; bus_if.mem_req_ack = 0;
    bus_if.mem_resp_v = 0; bus_if.mem_resp_data = '0; bus_if.dmd_v = 0; bus_if.dmd_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_count", 32'(bus_if.count), 0);
    check("reset_req_v", 32'(bus_if.mem_req_v), 0);
    check("reset_drop",  32'(bus_if.pf_drop), 0);
    check("reset_hit",   32'(bus_if.dmd_hit), 0);
    rst_n = 1'b1;
    idle();

    // Basic round trip
    pf(16'h0040);
    check("t1_count_1",  32'(bus_if.count), 1);
    check("t1_req_addr", 32'(bus_if.mem_req_addr), 32'h0040);
    ack();
    check("t1_req_v_0",  32'(bus_if.mem_req_v), 0);
    resp(16'hBEEF);
    dmd(16'h0040);
    check("t1_hit",      32'(bus_if.dmd_hit), 1);
    check("t1_data",     32'(bus_if.dmd_data), 32'hBEEF);
    check("t1_count_0",  32'(bus_if.count), 0);
    idle();
    check("t1_hit_pulse", 32'(bus_if.dmd_hit), 0);
    check("t1_data_zero", 32'(bus_if.dmd_data), 0);

    // Duplicate candidate
    pf(16'h0040);
    pf(16'h0040);
    check("t2_drop",  32'(bus_if.pf_drop), 1);
    check("t2_count", 32'(bus_if.count), 1);
    idle();
    check("t2_drop_pulse", 32'(bus_if.pf_drop), 0);
    dmd(16'h0040);
    check("t2_cancel_count", 32'(bus_if.count), 0);

    // Fill to DEPTH, then overflow
    pf(16'h0010); pf(16'h0020); pf(16'h0030); pf(16'h0040);
    pf(16'h0050);
    check("t3_drop",     32'(bus_if.pf_drop), 1);
    check("t3_count",    32'(bus_if.count), 4);
    check("t3_req_addr", 32'(bus_if.mem_req_addr), 32'h0010);

    // Issue two, cancel the queued rest, then in-order responses
    ack();
    check("t4_req_addr_20", 32'(bus_if.mem_req_addr), 32'h0020);
    ack();
    dmd(16'h0030);
    check("t5_cancel_hit",  32'(bus_if.dmd_hit), 0);
    check("t5_skip_30",     32'(bus_if.mem_req_addr), 32'h0040);
    dmd(16'h0040);
    check("t4_count_2",     32'(bus_if.count), 2);
    resp(16'h1111);
    resp(16'h2222);
    dmd(16'h0020);
    check("t4_hit",   32'(bus_if.dmd_hit), 1);
    check("t4_data",  32'(bus_if.dmd_data), 32'h2222);
    check("t4_count", 32'(bus_if.count), 1);

    // Ack and cancel on the same queued entry: ack wins
    pf(16'h0030);
    check("t5_req_addr_30", 32'(bus_if.mem_req_addr), 32'h0030);
    step(0, '0, 1, 0, '0, 1, 16'h0030);
    check("t5_ack_wins_hit",   32'(bus_if.dmd_hit), 0);
    check("t5_ack_wins_count", 32'(bus_if.count), 2);
    check("t5_ack_wins_req_v", 32'(bus_if.mem_req_v), 0);

    // pf and demand on the same READY address
    step(1, 16'h0010, 0, 0, '0, 1, 16'h0010);
    check("sim_hit",   32'(bus_if.dmd_hit), 1);
    check("sim_data",  32'(bus_if.dmd_data), 32'h1111);
    check("sim_drop",  32'(bus_if.pf_drop), 1);
    check("sim_count", 32'(bus_if.count), 1);

    // Issue and response in the same cycle
    pf(16'h0070);
    step(0, '0, 1, 1, 16'h3333, 0, '0);
    pf(16'h0080);
    step(0, '0, 1, 1, 16'h7777, 0, '0);
    dmd(16'h0070);
    check("push_pop_data", 32'(bus_if.dmd_data), 32'h7777);
    pf(16'h0090);
    ack();
    check("pre_reset_count", 32'(bus_if.count), 3);

    // Reset mid-operation with two PENDING entries
    #2 rst_n = 1'b0;
    #1;
    check("t6_count", 32'(bus_if.count), 0);
    check("t6_req_v", 32'(bus_if.mem_req_v), 0);
    check("t6_addr",  32'(bus_if.mem_req_addr), 0);
    check("t6_drop",  32'(bus_if.pf_drop), 0);
    check("t6_hit",   32'(bus_if.dmd_hit), 0);
    check("t6_data",  32'(bus_if.dmd_data), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    resp(16'hDEAD);
    check("t6_stray_count", 32'(bus_if.count), 0);
    check("t6_stray_req_v", 32'(bus_if.mem_req_v), 0);
    dmd(16'h0030);
    check("t6_stray_hit", 32'(bus_if.dmd_hit), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
